// File: rtl/cmd_pkg.sv
// Shared definitions for the ASCII command parser: character constants,
// controller states and hex <-> ASCII helpers.
package cmd_pkg;

    localparam logic [7:0] CH_W = 8'h57;
    localparam logic [7:0] CH_R = 8'h52;
    localparam logic [7:0] CH_K = 8'h4b;
    localparam logic [7:0] CH_E = 8'h45;
    localparam logic [7:0] CR   = 8'h0d;
    localparam logic [7:0] LF   = 8'h0a;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_EXEC,
        ST_SEND,
        ST_WAIT_HI,
        ST_WAIT_LO
    } state_t;

    // Returns {valid, nibble}; valid is 0 for anything outside 0-9/A-F/a-f.
    function automatic logic [4:0] hex2nib(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return {1'b1, 4'(c - 8'h30)};
        if (c >= 8'h41 && c <= 8'h46) return {1'b1, 4'(c - 8'h37)};
        if (c >= 8'h61 && c <= 8'h66) return {1'b1, 4'(c - 8'h57)};
        return 5'b0;
    endfunction

    // Nibble to uppercase ASCII hex digit.
    function automatic logic [7:0] nib2hex(input logic [3:0] n);
        if (n < 4'd10) return 8'h30 + {4'h0, n};
        return 8'h37 + {4'h0, n};
    endfunction

endpackage

// File: rtl/cmd_parser_if.sv
// Command input and UART transmit handshake between the line-assembly
// stage / transmitter (master side) and the command parser (slave side).
interface cmd_parser_if;
    logic [31:0] info;
    logic        update;
    logic        tx_busy;
    logic        tx_start;
    logic [7:0]  tx_byte;

    modport master (
        output info, update, tx_busy,
        input  tx_start, tx_byte
    );

    modport slave (
        input  info, update, tx_busy,
        output tx_start, tx_byte
    );
endinterface

// File: rtl/cmd_reply_tx.sv
// Reply sequencer: holds up to four reply bytes and hands them one at a time
// to the UART transmitter, waiting for a full busy high/low cycle per byte.
module cmd_reply_tx
    import cmd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_load,
    input  logic [2:0]  i_len,
    input  logic [31:0] i_bytes,
    input  logic        i_tx_busy,
    output logic        o_tx_start,
    output logic [7:0]  o_tx_byte,
    output logic        o_done
);

    state_t     r_state;
    logic [7:0] r_buf [4];
    logic [2:0] r_len;
    logic [1:0] r_idx;
    logic       w_last;

    assign w_last     = ({1'b0, r_idx} == (r_len - 3'd1));
    // Start is offered in the SEND cycle itself so the first byte can go out
    // three cycles after the command strobe.
    assign o_tx_start = (r_state == ST_SEND) && !i_tx_busy;
    assign o_tx_byte  = r_buf[r_idx];
    assign o_done     = (r_state == ST_WAIT_LO) && !i_tx_busy && w_last;

    // Byte sequencer: load buffer, then SEND -> WAIT_HI -> WAIT_LO per byte.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_len   <= 3'd0;
            r_idx   <= 2'd0;
            for (int i = 0; i < 4; i++) r_buf[i] <= 8'h00;
        end else if (i_load) begin
            for (int i = 0; i < 4; i++) r_buf[i] <= i_bytes[8*i +: 8];
            r_len   <= i_len;
            r_idx   <= 2'd0;
            r_state <= ST_SEND;
        end else begin
            unique case (r_state)
                ST_SEND:    if (!i_tx_busy) r_state <= ST_WAIT_HI;
                ST_WAIT_HI: if (i_tx_busy)  r_state <= ST_WAIT_LO;
                ST_WAIT_LO: begin
                    if (!i_tx_busy) begin
                        if (w_last) begin
                            r_state <= ST_IDLE;
                        end else begin
                            r_idx   <= r_idx + 2'd1;
                            r_state <= ST_SEND;
                        end
                    end
                end
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/cmd_parser.sv
// ASCII command parser: decodes 4-char read/write commands against a small
// byte-wide register bank and streams a CR LF terminated reply to the UART.
module cmd_parser
    import cmd_pkg::*;
#(
    parameter int NREG = 8,
    parameter int AW   = 4
) (
    input  logic              sys_clk,
    input  logic              rst_n,
    cmd_parser_if.slave       bus,
    output logic [NREG*8-1:0] reg_bus,
    output logic              wr_strobe,
    output logic [AW-1:0]     wr_addr,
    output logic              busy,
    output logic [7:0]        drop_cnt
);

    state_t        r_state;
    logic [31:0]   r_cmd;
    logic          r_do_wr;
    logic          r_do_rd;
    logic [AW-1:0] r_addr;
    logic [7:0]    r_data;
    logic          r_wr_strobe;
    logic [AW-1:0] r_wr_addr;
    logic [7:0]    r_drop_cnt;
    logic [7:0]    r_regs [NREG];

    logic [4:0]    w_addr_nib;
    logic [4:0]    w_hi_nib;
    logic [4:0]    w_lo_nib;
    logic          w_op_wr;
    logic          w_op_rd;
    logic          w_addr_ok;
    logic          w_wr_ok;
    logic [7:0]    w_rd_val;
    logic [2:0]    w_len;
    logic [31:0]   w_bytes;
    logic          w_load;
    logic          w_done;

    assign w_addr_nib = hex2nib(r_cmd[15:8]);
    assign w_hi_nib   = hex2nib(r_cmd[23:16]);
    assign w_lo_nib   = hex2nib(r_cmd[31:24]);
    assign w_op_wr    = (r_cmd[7:0] == CH_W) || (r_cmd[7:0] == (CH_W | 8'h20));
    assign w_op_rd    = (r_cmd[7:0] == CH_R) || (r_cmd[7:0] == (CH_R | 8'h20));
    assign w_addr_ok  = w_addr_nib[4] && ({1'b0, w_addr_nib[3:0]} < 5'(NREG));
    assign w_wr_ok    = w_op_wr && w_addr_ok && w_hi_nib[4] && w_lo_nib[4];
    assign w_load     = (r_state == ST_EXEC);

    // Read mux and reply assembly (byte 0 is sent first).
    always_comb begin
        w_rd_val = 8'h00;
        for (int i = 0; i < NREG; i++) begin
            if (r_addr == AW'(i)) w_rd_val = r_regs[i];
        end
        w_len   = 3'd3;
        w_bytes = {8'h00, LF, CR, CH_E};
        if (r_do_wr) begin
            w_bytes = {8'h00, LF, CR, CH_K};
        end else if (r_do_rd) begin
            w_len   = 3'd4;
            w_bytes = {LF, CR, nib2hex(w_rd_val[3:0]), nib2hex(w_rd_val[7:4])};
        end
    end

    // Flatten the register bank for the experiment-control side.
    always_comb begin
        reg_bus = '0;
        for (int i = 0; i < NREG; i++) reg_bus[8*i +: 8] = r_regs[i];
    end

    // Command FSM: accept in IDLE, decode, execute, then wait for the reply.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_cmd       <= 32'h0;
            r_do_wr     <= 1'b0;
            r_do_rd     <= 1'b0;
            r_addr      <= '0;
            r_data      <= 8'h00;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_drop_cnt  <= 8'h00;
            for (int i = 0; i < NREG; i++) r_regs[i] <= 8'h00;
        end else begin
            r_wr_strobe <= 1'b0;
            // Only an update seen in IDLE is taken; anything else is a drop.
            if (bus.update && (r_state != ST_IDLE) && (r_drop_cnt != 8'hff))
                r_drop_cnt <= r_drop_cnt + 8'd1;
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.update) begin
                        r_cmd   <= bus.info;
                        r_state <= ST_DECODE;
                    end
                end
                ST_DECODE: begin
                    r_do_wr <= w_wr_ok;
                    r_do_rd <= w_op_rd && w_addr_ok;
                    r_addr  <= AW'(w_addr_nib[3:0]);
                    r_data  <= {w_hi_nib[3:0], w_lo_nib[3:0]};
                    // Strobe and address become visible together in EXEC.
                    r_wr_strobe <= w_wr_ok;
                    if (w_wr_ok) r_wr_addr <= AW'(w_addr_nib[3:0]);
                    r_state <= ST_EXEC;
                end
                ST_EXEC: begin
                    if (r_do_wr) begin
                        for (int i = 0; i < NREG; i++) begin
                            if (r_addr == AW'(i)) r_regs[i] <= r_data;
                        end
                    end
                    r_state <= ST_SEND;
                end
                ST_SEND: begin
                    if (w_done) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    cmd_reply_tx u_tx (
        .clk        (sys_clk),
        .rst_n      (rst_n),
        .i_load     (w_load),
        .i_len      (w_len),
        .i_bytes    (w_bytes),
        .i_tx_busy  (bus.tx_busy),
        .o_tx_start (bus.tx_start),
        .o_tx_byte  (bus.tx_byte),
        .o_done     (w_done)
    );

    assign wr_strobe = r_wr_strobe;
    assign wr_addr   = r_wr_addr;
    assign busy      = (r_state != ST_IDLE);
    assign drop_cnt  = r_drop_cnt;

endmodule

// File: tb/tb_cmd_parser.sv
// Directed bench for cmd_parser with a 10-cycle-per-byte UART model.
module tb_cmd_parser;

    localparam int NREG = 8;
    localparam int AW   = 4;

    logic              sys_clk = 1'b0;
    logic              rst_n   = 1'b0;
    logic [NREG*8-1:0] reg_bus;
    logic              wr_strobe;
    logic [AW-1:0]     wr_addr;
    logic              busy;
    logic [7:0]        drop_cnt;

    cmd_parser_if bus();

    cmd_parser #(.NREG(NREG), .AW(AW)) u_dut (
        .sys_clk   (sys_clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .reg_bus   (reg_bus),
        .wr_strobe (wr_strobe),
        .wr_addr   (wr_addr),
        .busy      (busy),
        .drop_cnt  (drop_cnt)
    );

    always #5 sys_clk = ~sys_clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // UART transmitter model: busy for 10 cycles after each start.
    int   m_cnt;
    logic hold_busy = 1'b0;
    always @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n)             m_cnt <= 0;
        else if (bus.tx_start)  m_cnt <= 10;
        else if (m_cnt > 0)     m_cnt <= m_cnt - 1;
    end
    assign bus.tx_busy = (m_cnt != 0) | hold_busy;

    // Capture transmitted bytes and watch handshake rules.
    logic [7:0] cap[$];
    int         wr_cnt   = 0;
    int         consec   = 0;
    int         unstable = 0;
    logic       prev_start = 1'b0;
    logic [7:0] held = 8'h00;
    always @(posedge sys_clk) begin
        if (rst_n) begin
            if (bus.tx_start) begin
                cap.push_back(bus.tx_byte);
                held <= bus.tx_byte;
                if (prev_start) consec <= consec + 1;
            end
            if (wr_strobe) wr_cnt <= wr_cnt + 1;
        end
        prev_start <= bus.tx_start;
    end
    always @(negedge sys_clk) begin
        if (rst_n && m_cnt != 0 && bus.tx_byte != held) unstable <= unstable + 1;
    end

    logic [7:0] exp_regs [NREG];

    function automatic logic [63:0] pack_regs();
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < NREG; i++) r[8*i +: 8] = exp_regs[i];
        return r;
    endfunction

    task automatic pulse(input logic [31:0] v);
        @(negedge sys_clk);
        bus.info   = v;
        bus.update = 1'b1;
        @(posedge sys_clk);
        #1;
        bus.update = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while ((busy || bus.tx_busy) && n < 500) begin
            @(posedge sys_clk);
            #1;
            n++;
        end
        checks++;
        if (busy || bus.tx_busy) begin
            errors++;
            $display("FAIL %s timeout busy=%0b required=0", name, busy);
        end
    endtask

    typedef struct {
        logic [31:0] info;
        logic [31:0] rep;
        int          len;
        logic        wr;
        int          ridx;
        logic [7:0]  rval;
    } vec_t;

    localparam logic [31:0] REP_K = 32'h000a0d4b;
    localparam logic [31:0] REP_E = 32'h000a0d45;

    task automatic run_vec(input vec_t v, input int id);
        int wr0;
        cap.delete();
        wr0 = wr_cnt;
        pulse(v.info);
        chk($sformatf("v%0d busy_decode", id), busy, 1);
        chk($sformatf("v%0d wr_strobe_decode", id), wr_strobe, 0);
        @(posedge sys_clk); #1;
        chk($sformatf("v%0d wr_strobe_exec", id), wr_strobe, v.wr);
        if (v.wr) chk($sformatf("v%0d wr_addr", id), wr_addr, v.ridx);
        @(posedge sys_clk); #1;
        chk($sformatf("v%0d tx_start_n3", id), bus.tx_start, 1);
        wait_idle($sformatf("v%0d idle", id));
        if (v.wr) exp_regs[v.ridx] = v.rval;
        chk($sformatf("v%0d reply_len", id), cap.size(), v.len);
        for (int i = 0; i < v.len; i++)
            chk($sformatf("v%0d reply_byte%0d", id, i),
                (i < cap.size()) ? cap[i] : 8'hxx, v.rep[8*i +: 8]);
        chk($sformatf("v%0d reg_bus", id), reg_bus, pack_regs());
        chk($sformatf("v%0d wr_pulses", id), wr_cnt - wr0, v.wr);
    endtask

    vec_t vecs [9];

    initial begin
        int n;
        vecs[0] = '{32'h35413357, REP_K,        3, 1'b1, 3, 8'ha5}; // W3A5
        vecs[1] = '{32'h78783352, 32'h0a0d3541, 4, 1'b0, 0, 8'h00}; // R3xx
        vecs[2] = '{32'h20203952, REP_E,        3, 1'b0, 0, 8'h00}; // R9
        vecs[3] = '{32'h30303151, REP_E,        3, 1'b0, 0, 8'h00}; // Q100
        vecs[4] = '{32'h30473157, REP_E,        3, 1'b0, 0, 8'h00}; // W1G0
        vecs[5] = '{32'h32623777, REP_K,        3, 1'b1, 7, 8'hb2}; // w7b2
        vecs[6] = '{32'h00003772, 32'h0a0d3242, 4, 1'b0, 0, 8'h00}; // r7
        vecs[7] = '{32'h30304157, REP_E,        3, 1'b0, 0, 8'h00}; // WA00
        vecs[8] = '{32'h00003072, 32'h0a0d3030, 4, 1'b0, 0, 8'h00}; // r0
        for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;

        bus.info   = 32'h0;
        bus.update = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        chk("rst tx_start", bus.tx_start, 0);
        chk("rst tx_byte", bus.tx_byte, 0);
        chk("rst busy", busy, 0);
        chk("rst drop_cnt", drop_cnt, 0);
        chk("rst reg_bus", reg_bus, 0);
        chk("rst wr_addr", wr_addr, 0);
        @(negedge sys_clk);
        rst_n = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(vecs[i], i);

        // Second command while a reply is in flight is dropped.
        cap.delete();
        pulse(32'h41353257);                       // W25A
        n = 0;
        while (cap.size() < 1 && n < 100) begin @(posedge sys_clk); #1; n++; end
        chk("drop first_byte_seen", cap.size(), 1);
        pulse(32'h46463257);                       // W2FF, must be ignored
        chk("drop drop_cnt", drop_cnt, 1);
        wait_idle("drop idle");
        exp_regs[2] = 8'h5a;
        chk("drop reply_len", cap.size(), 3);
        chk("drop reg_bus", reg_bus, pack_regs());

        // Transmitter busy for 50 cycles before the reply may start.
        cap.delete();
        hold_busy = 1'b1;
        pulse(32'h00003252);                       // R2
        repeat (50) @(posedge sys_clk);
        #1;
        chk("hold no_start", cap.size(), 0);
        chk("hold busy", busy, 1);
        hold_busy = 1'b0;
        wait_idle("hold idle");
        chk("hold reply_len", cap.size(), 4);
        if (cap.size() == 4)
            chk("hold reply", {cap[3], cap[2], cap[1], cap[0]}, 32'h0a0d4135);

        // Asynchronous reset in WAIT_LO of a read reply.
        cap.delete();
        pulse(32'h00003352);                       // R3
        n = 0;
        while (cap.size() < 1 && n < 100) begin @(posedge sys_clk); #1; n++; end
        chk("arst first_byte_seen", cap.size(), 1);
        repeat (3) @(posedge sys_clk);
        @(negedge sys_clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst tx_start", bus.tx_start, 0);
        chk("arst tx_byte", bus.tx_byte, 0);
        chk("arst busy", busy, 0);
        chk("arst drop_cnt", drop_cnt, 0);
        chk("arst reg_bus", reg_bus, 0);
        chk("arst wr_strobe", wr_strobe, 0);
        chk("arst wr_addr", wr_addr, 0);
        for (int i = 0; i < NREG; i++) exp_regs[i] = 8'h00;
        @(negedge sys_clk);
        rst_n = 1'b1;
        run_vec('{32'h66663077, REP_K, 3, 1'b1, 0, 8'hff}, 9);  // w0ff

        chk("no_consecutive_start", consec, 0);
        chk("tx_byte_stable", unstable, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_parser.md
Name: cmd_parser

Overview:
- Consumes the 32-bit ASCII command word and `update` strobe produced by the UART line-assembly stage: 4 chars, byte 0 in bits [7:0], first received char.
- Decodes read/write commands against a small byte-wide register bank.
- Streams an ASCII reply, terminated by CR LF, to the UART transmitter through a start/busy handshake.
- Sits between the UART front end and the experiment-control logic that reads `reg_bus`.

Parameters:
- NREG, 8, number of 8-bit registers; 2..16.
- AW, 4, address width; must satisfy 2^AW >= NREG.

Ports:
- sys_clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- info  in  32  command chars; [7:0] = opcode, [15:8] = address, [23:16] = data hi nibble, [31:24] = data lo nibble
- update  in  1  one-cycle strobe; `info` is valid in the same cycle
- tx_busy  in  1  transmitter busy (UART is_transmitting)
- tx_start  out  1  one-cycle request to send `tx_byte`
- tx_byte  out  8  byte to transmit
- reg_bus  out  NREG*8  flattened register bank; reg i at [8i+7:8i]
- wr_strobe  out  1  one-cycle pulse on a register write
- wr_addr  out  AW  address of the last write
- busy  out  1  high whenever state != IDLE
- drop_cnt  out  8  saturating count of commands dropped while busy

Behaviour:
- Reset (async, rst_n=0): state=IDLE; tx_start=0; tx_byte=0; reg_bus=0; wr_strobe=0; wr_addr=0; busy=0; drop_cnt=0; reply buffer and indices cleared. Reset mid-reply abandons the reply immediately.
- Hex decode: '0'-'9', 'A'-'F', 'a'-'f' map to 0..15; any other char is invalid.
- Opcodes: 'W' (0x57) or 'w' is write; 'R' (0x52) or 'r' is read; anything else is an error.
- Address: one hex char; invalid if not hex or value >= NREG.
- Data: two hex chars, checked only for writes; hi nibble = info[23:16]. Reads ignore bytes 2-3.
- State machine: IDLE -> DECODE -> EXEC -> SEND -> WAIT_HI -> WAIT_LO -> (SEND | IDLE).
- IDLE:
  - update=1: latch info into cmd register; go to DECODE.
  - update=0: stay in IDLE.
- DECODE (1 cycle): evaluate opcode, address and data validity into registered flags; go to EXEC.
- EXEC (1 cycle): load the reply buffer (max 4 bytes) with length rlen and set ridx=0; go to SEND.
  - Valid write: reg[addr] <= data; wr_strobe=1 for exactly this cycle; wr_addr <= addr; reply "K",CR,LF (rlen=3).
  - Valid read: reply two uppercase hex chars of reg[addr] (hi first), then CR,LF (rlen=4).
  - Error: no register change; reply "E",CR,LF (rlen=3).
- SEND: when tx_busy=0, set tx_byte=buf[ridx] and tx_start=1 for one cycle; go to WAIT_HI. While tx_busy=1, hold.
- WAIT_HI: wait for tx_busy=1, then go to WAIT_LO. No timeout.
- WAIT_LO: wait for tx_busy=0, then:
  - ridx==rlen-1: go to IDLE.
  - otherwise: ridx++, go to SEND.
- Latency:
  - update in cycle n: DECODE n+1, EXEC n+2 (wr_strobe at n+2).
  - Earliest tx_start is n+3, if tx_busy=0.
- update while busy=1: command ignored; drop_cnt increments, saturating at 255.
- update in the same cycle the FSM returns to IDLE: counted as a drop. Only an update seen while in IDLE is accepted.
- tx_start never asserts in two consecutive cycles. tx_byte is held stable from tx_start until the WAIT_LO exit.
- reg_bus changes only in EXEC of a valid write.

Decomposition:
- Shared package cmd_pkg holds:
  - char constants: CH_W, CH_R, CH_K, CH_E, CR=8'h0d, LF=8'h0a;
  - the state enum;
  - function hex2nib (char -> {valid, nibble});
  - function nib2hex (nibble -> uppercase char).
- Natural sub-module: cmd_reply_tx, covering the SEND/WAIT_HI/WAIT_LO sequencer plus the 4-byte buffer. Its interface is load, len, bytes, tx_busy, tx_start, tx_byte, done.

Test Plan:
- "W3A5" (info=32'h35_41_33_57), update pulse -> wr_strobe at n+2, wr_addr=3, reg_bus[31:24]=8'hA5; tx bytes 'K', 0x0d, 0x0a.
- After the above, "R3xx" -> tx bytes 0x41 ('A'), 0x35 ('5'), 0x0d, 0x0a; no wr_strobe.
- "R9" with NREG=8, "Q100", and "W1G0" -> each replies 'E', 0x0d, 0x0a; reg_bus unchanged.
- Second update pulse while replying, tx_busy model 10 cycles per byte -> drop_cnt=1; only one reply stream.
- Hold tx_busy=1 for 50 cycles before a reply -> no tx_start until tx_busy falls; then exactly one tx_start per byte.
- Assert rst_n=0 during WAIT_LO of a read reply -> all outputs at reset values asynchronously; after release, "w0ff" writes reg0=8'hFF.
